// File: rtl/dcache_pkg.sv
// Shared types and address-width helpers for the two-way write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } dcache_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = $clog2(WORD_BYTES);

  function automatic int offset_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int num_sets, input int words_per_line);
    return 32 - BYTE_W - offset_width(words_per_line) - index_width(num_sets);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty flags, tag and line storage with a combinational
// read port and a byte-enabled synchronous write port.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFF_W = offset_width(WORDS_PER_LINE),
  localparam int IDX_W = index_width(NUM_SETS),
  localparam int TAG_W = tag_width(NUM_SETS, WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      index,
  input  logic [OFF_W-1:0]      rd_offset,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [31:0]           rd_word,
  input  logic                  wr_en,
  input  logic [OFF_W-1:0]      wr_offset,
  input  logic [31:0]           wr_data,
  input  logic [WORD_BYTES-1:0] wr_be,
  input  logic                  wr_set_dirty,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic                  clr_dirty
);

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  logic [31:0]         data [NUM_SETS*WORDS_PER_LINE];

  assign rd_tag   = tags[index];
  assign rd_valid = valid[index];
  assign rd_dirty = dirty[index];
  assign rd_word  = data[{index, rd_offset}];

  // Line status flags; a completed refill leaves the line valid and clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (clr_dirty) begin
      dirty[index] <= 1'b0;
    end else if (wr_en && wr_set_dirty) begin
      dirty[index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[index] <= line_tag;
    end
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (wr_en && wr_be[b]) begin
        data[{index, wr_offset}][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Two-way set-associative write-back, write-allocate data cache controller:
// same-cycle hits, and writeback/refill bursts over a one-beat memory port.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_en,
  output logic [31:0] cpu_rdata,
  output logic        cache_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OFF_W = offset_width(WORDS_PER_LINE);
  localparam int IDX_W = index_width(NUM_SETS);
  localparam int TAG_W = tag_width(NUM_SETS, WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  dcache_state_t       state;
  logic [OFF_W-1:0]    beat;
  logic                victim;
  logic [NUM_SETS-1:0] lru;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] index;
  logic [OFF_W-1:0] offset;
  logic             unused_byte_bits;

  assign req_tag          = cpu_addr[31 -: TAG_W];
  assign index            = cpu_addr[BYTE_W+OFF_W +: IDX_W];
  assign offset           = cpu_addr[BYTE_W +: OFF_W];
  assign unused_byte_bits = ^cpu_addr[BYTE_W-1:0];

  logic [TAG_W-1:0]      way_tag   [2];
  logic [31:0]           way_word  [2];
  logic [1:0]            way_valid, way_dirty, way_hit;
  logic [1:0]            wr_en, line_we, clr_dirty;
  logic [OFF_W-1:0]      rd_offset, wr_offset;
  logic [31:0]           wr_data;
  logic [WORD_BYTES-1:0] wr_be;
  logic                  wr_set_dirty;

  // Writeback reads the victim line beat by beat; refill writes it the same way.
  assign rd_offset = (state == WRITEBACK) ? beat : offset;
  assign wr_offset = (state == REFILL) ? beat : offset;

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(
      .NUM_SETS      (NUM_SETS),
      .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .index       (index),
      .rd_offset   (rd_offset),
      .rd_tag      (way_tag[w]),
      .rd_valid    (way_valid[w]),
      .rd_dirty    (way_dirty[w]),
      .rd_word     (way_word[w]),
      .wr_en       (wr_en[w]),
      .wr_offset   (wr_offset),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .wr_set_dirty(wr_set_dirty),
      .line_we     (line_we[w]),
      .line_tag    (req_tag),
      .clr_dirty   (clr_dirty[w])
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
  end

  logic req, hit, hit_way, victim_sel, victim_dirty, last;

  assign req          = cpu_read | cpu_write;
  assign hit          = |way_hit;
  assign hit_way      = way_hit[1];
  assign victim_sel   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[index]);
  assign victim_dirty = way_valid[victim_sel] & way_dirty[victim_sel];
  assign last         = (beat == LAST_BEAT);

  // Hit/stall decode, way write steering and memory-port muxing.
  always_comb begin
    cpu_rdata    = 32'd0;
    cache_stall  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    wr_en        = 2'b00;
    line_we      = 2'b00;
    clr_dirty    = 2'b00;
    wr_data      = cpu_wdata;
    wr_be        = cpu_byte_en;
    wr_set_dirty = 1'b0;
    case (state)
      IDLE: begin
        if (req && hit) begin
          cpu_rdata          = way_word[hit_way];
          wr_en[hit_way]     = cpu_write;
          wr_set_dirty       = 1'b1;
        end else begin
          cache_stall = req;
        end
      end
      WRITEBACK: begin
        cache_stall       = 1'b1;
        mem_req           = 1'b1;
        mem_we            = 1'b1;
        mem_addr          = {way_tag[victim], index, beat, {BYTE_W{1'b0}}};
        mem_wdata         = way_word[victim];
        clr_dirty[victim] = mem_ack && last;
      end
      REFILL: begin
        cache_stall     = 1'b1;
        mem_req         = 1'b1;
        mem_addr        = {req_tag, index, beat, {BYTE_W{1'b0}}};
        wr_data         = mem_rdata;
        wr_be           = {WORD_BYTES{1'b1}};
        wr_en[victim]   = mem_ack;
        line_we[victim] = mem_ack && last;
      end
      default: begin
        cache_stall = 1'b1;
      end
    endcase
  end

  // Miss FSM, beat counter, victim latch and per-set LRU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      victim <= 1'b0;
      lru    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            lru[index] <= ~hit_way;
          end else if (req) begin
            beat   <= '0;
            victim <= victim_sel;
            state  <= victim_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            beat <= last ? '0 : beat + OFF_W'(1);
            if (last) state <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            beat <= last ? '0 : beat + OFF_W'(1);
            if (last) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

endmodule
